// File: rtl/ctd_pkg.sv
// rtl/ctd_pkg.sv - shared constants for the minute countdown controller
package ctd_pkg;

  // BCD digit geometry
  localparam int                 DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // Saturate an out-of-range BCD digit to 9
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > MAX_DIGIT) ? MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/bcd_dec2.sv
// rtl/bcd_dec2.sv - two-digit BCD decrement with zero flag, combinational
module bcd_dec2
  import ctd_pkg::*;
(
  input  logic [2*DIGIT_W-1:0] bcd_in,
  output logic [2*DIGIT_W-1:0] bcd_out,
  output logic                 zero
);

  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] units;

  assign tens  = bcd_in[2*DIGIT_W-1:DIGIT_W];
  assign units = bcd_in[DIGIT_W-1:0];
  assign zero  = (bcd_in == '0);

  // Units borrow from tens when at 0; 00 holds rather than wrapping to 99
  always_comb begin
    bcd_out = bcd_in;
    if (!zero) begin
      if (units == '0) begin
        bcd_out = {tens - 4'd1, MAX_DIGIT};
      end else begin
        bcd_out = {tens, units - 4'd1};
      end
    end
  end

endmodule

// File: rtl/ctd_min_ctrl.sv
// rtl/ctd_min_ctrl.sv - minute register and run/pause/done FSM of a countdown timer
module ctd_min_ctrl
  import ctd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       load_req,
  input  logic [7:0] preset_min,
  input  logic       pulse_in,
  input  logic [7:0] sec_x,
  input  logic       sec_borrow,
  output logic       cnt_en,
  output logic       load,
  output logic [7:0] min_x,
  output logic [1:0] state,
  output logic       done,
  output logic       done_pulse
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [7:0] min_q;
  logic [7:0] min_d;
  logic       done_pulse_q;
  logic [7:0] min_dec;
  logic       min_zero;
  logic [7:0] preset_clamped;
  logic       cnt_zero;
  logic       load_ok;
  logic       borrow_ok;
  logic [1:0] tick_gap;

  bcd_dec2 u_min_dec (
    .bcd_in  (min_q),
    .bcd_out (min_dec),
    .zero    (min_zero)
  );

  assign preset_clamped = {clamp_digit(preset_min[7:4]), clamp_digit(preset_min[3:0])};
  assign cnt_zero       = min_zero && (sec_x == 8'h00);
  // A load is honoured everywhere except while actively counting
  assign load_ok        = (state_q != ST_RUN);
  assign borrow_ok      = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && !min_zero;

  // Next-state decode; zero-detect has priority over pause while running
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!load_req && start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_zero)   state_d = ST_DONE;
        else if (pause) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (load_req)   state_d = ST_IDLE;
        else if (start) state_d = ST_RUN;
      end
      ST_DONE: begin
        if (load_req)   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Minute register next value; a load beats a simultaneous borrow
  always_comb begin
    min_d = min_q;
    if (load_req && load_ok) begin
      min_d = preset_clamped;
    end else if (sec_borrow && borrow_ok) begin
      min_d = min_dec;
    end
  end

  // State, minutes and the DONE entry strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      min_q        <= 8'h00;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_q        <= min_d;
      done_pulse_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  // Clocks since the last seconds tick, saturating at 3, for the spacing check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_gap <= 2'd3;
    end else if (pulse_in) begin
      tick_gap <= 2'd0;
    end else if (tick_gap != 2'd3) begin
      tick_gap <= tick_gap + 2'd1;
    end
  end

  tick_spacing_a: assert property (@(posedge clk) disable iff (!rst_n)
    pulse_in |-> (tick_gap >= 2'd2));

  assign cnt_en     = (state_q == ST_RUN);
  assign load       = (state_q != ST_RUN);
  assign min_x      = min_q;
  assign state      = state_q;
  assign done       = (state_q == ST_DONE);
  assign done_pulse = done_pulse_q;

endmodule
